mem_responder: RTL and testbench

- Byte-addressed memory that responds to the control unit's memory-operation handshake: MOV request, R/W direction, MAR address, MDR data.
- Returns MOC (memory operation complete) after a programmable number of wait states.
- Completes the datapath's memory interface: sits between MAR/MDR and the control unit's MOC input.
- Storage is big-endian; byte, halfword and word accesses are supported.

---
 rtl/mem_responder.sv | 163 ++++++++++++++++
 tb/tb_mem_responder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: byte-addressed big-endian memory answering the control
// unit's MOV/MOC handshake after a fixed number of wait states.
// Supports byte, halfword and word transfers; flags misaligned or
// reserved-type accesses through ERR.
module mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        MOV,
    input  logic        RW,
    input  logic [1:0]  DATA_TYPE,
    input  logic [31:0] ADDR,
    input  logic [31:0] DATA_IN,
    output logic [31:0] DATA_OUT,
    output logic        MOC,
    output logic        ERR
);

    localparam int DEPTH = 1 << ADDR_W;

    // Wait-state counter value on which the access is carried out.
    localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_reg;
    logic [3:0]         cnt_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic               rw_reg;
    logic [1:0]         type_reg;
    logic [31:0]        data_reg;

    logic [7:0]         mem_array [0:DEPTH-1];

    // Per-lane byte address, write enable, write byte and read byte.
    // Lane 0 is the most significant byte of the transfer (big-endian).
    logic [ADDR_W-1:0]  lane_addr  [4];
    logic               lane_en    [4];
    logic [7:0]         lane_wdata [4];
    logic [7:0]         rd_bytes   [4];

    logic               access_now;
    logic               err_calc;
    logic               wr_go;
    logic [31:0]        rd_data;

    // Address bits above the array size are deliberately ignored.
    generate
        if (ADDR_W < 32) begin : g_addr_unused
            logic unused_addr_bits;
            assign unused_addr_bits = ^ADDR[31:ADDR_W];
        end
    endgenerate

    // Byte lanes: the captured address is aligned whenever a lane beyond
    // lane 0 is enabled, so A+i never wraps past the end of the array.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_addr[gi] = addr_reg + ADDR_W'(gi);
            assign lane_en[gi]   = (type_reg == 2'b10)
                                 || ((type_reg == 2'b01) && (gi < 2))
                                 || ((type_reg == 2'b00) && (gi == 0));
            assign lane_wdata[gi] = (type_reg == 2'b00) ? data_reg[7:0] :
                                    (type_reg == 2'b01) ? ((gi == 0) ? data_reg[15:8] : data_reg[7:0]) :
                                    data_reg[31-8*gi -: 8];
            assign rd_bytes[gi]  = mem_array[lane_addr[gi]];
        end
    endgenerate

    assign access_now = (state_reg == ST_WAIT) && (cnt_reg == LAST_CNT);

    // Alignment and type check on the captured request.
    always_comb begin
        err_calc = 1'b0;
        case (type_reg)
            2'b00:   err_calc = 1'b0;
            2'b01:   err_calc = addr_reg[0];
            2'b10:   err_calc = (addr_reg[1:0] != 2'b00);
            default: err_calc = 1'b1;
        endcase
    end

    // Assemble zero-extended read data from the byte lanes.
    always_comb begin
        rd_data = 32'd0;
        case (type_reg)
            2'b00:   rd_data = {24'd0, rd_bytes[0]};
            2'b01:   rd_data = {16'd0, rd_bytes[0], rd_bytes[1]};
            default: rd_data = {rd_bytes[0], rd_bytes[1], rd_bytes[2], rd_bytes[3]};
        endcase
    end

    // A reset on the access edge suppresses the write.
    assign wr_go = access_now && !rw_reg && !err_calc && RST_N;

    // Memory array write port; contents survive reset.
    always_ff @(posedge CLK) begin
        if (wr_go) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem_array[lane_addr[i]] <= lane_wdata[i];
                end
            end
        end
    end

    // Handshake FSM: capture, count wait states, complete, await MOV release.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            MOC       <= 1'b0;
            ERR       <= 1'b0;
            DATA_OUT  <= 32'd0;
            addr_reg  <= '0;
            rw_reg    <= 1'b0;
            type_reg  <= 2'b00;
            data_reg  <= 32'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (MOV) begin
                        addr_reg  <= ADDR[ADDR_W-1:0];
                        rw_reg    <= RW;
                        type_reg  <= DATA_TYPE;
                        data_reg  <= DATA_IN;
                        cnt_reg   <= 4'd0;
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (access_now) begin
                        MOC       <= 1'b1;
                        ERR       <= err_calc;
                        if (rw_reg && !err_calc) begin
                            DATA_OUT <= rd_data;
                        end
                        state_reg <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (!MOV) begin
                        MOC       <= 1'b0;
                        ERR       <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: directed requests; expected completions are
// queued by the driver and checked by an independent monitor on MOC rise.
module tb_mem_responder;

    localparam int ADDR_W  = 8;
    localparam int LATENCY = 2;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        MOV;
    logic        RW;
    logic [1:0]  DATA_TYPE;
    logic [31:0] ADDR;
    logic [31:0] DATA_IN;
    logic [31:0] DATA_OUT;
    logic        MOC;
    logic        ERR;

    mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .MOV       (MOV),
        .RW        (RW),
        .DATA_TYPE (DATA_TYPE),
        .ADDR      (ADDR),
        .DATA_IN   (DATA_IN),
        .DATA_OUT  (DATA_OUT),
        .MOC       (MOC),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cap;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every rising MOC must match the oldest queued expectation.
    initial begin : monitor
        logic moc_prev;
        exp_t e;
        moc_prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (MOC === 1'b1 && moc_prev !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_moc: got MOC=1 at cycle %0d expected no completion", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_data"}, DATA_OUT, e.data);
                    chk({e.name, "_err"}, {31'd0, ERR}, {31'd0, e.err});
                    chk({e.name, "_latency"}, 32'(cyc - e.cap), 32'(LATENCY));
                    $display("[TB] %s: DATA_OUT=0x%08h ERR=%0d latency=%0d", e.name, DATA_OUT, ERR, cyc - e.cap);
                end
            end
            moc_prev = MOC;
        end
    end

    // Issue one request; inputs are scrambled after the capture edge to
    // prove the captured copy is used. hold = extra cycles MOV stays high.
    task automatic do_op(input string name, input logic rw, input logic [1:0] dt,
                         input logic [31:0] addr, input logic [31:0] din,
                         input logic [31:0] exp_data, input logic exp_err, input int hold);
        exp_t e;
        int n;
        @(negedge CLK);
        MOV = 1'b1; RW = rw; DATA_TYPE = dt; ADDR = addr; DATA_IN = din;
        e.data = exp_data; e.err = exp_err; e.cap = cyc + 1; e.name = name;
        exp_q.push_back(e);
        @(negedge CLK);
        ADDR = $urandom; DATA_IN = $urandom; RW = ~rw; DATA_TYPE = ~dt;
        n = 0;
        while (MOC !== 1'b1 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (MOC !== 1'b1) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s_timeout: got MOC=%b expected 1 within 40 cycles", name, MOC);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge CLK);
            chk({name, "_hold_moc"}, {31'd0, MOC}, 32'd1);
        end
        MOV = 1'b0;
        @(negedge CLK);
        chk({name, "_moc_drop"}, {31'd0, MOC}, 32'd0);
        chk({name, "_err_drop"}, {31'd0, ERR}, 32'd0);
    endtask

    initial begin : driver
        RST_N = 1'b0; MOV = 1'b1; RW = 1'b0; DATA_TYPE = 2'b10; ADDR = 32'd0; DATA_IN = 32'd0;
        repeat (3) @(negedge CLK);
        chk("reset_moc", {31'd0, MOC}, 32'd0);
        chk("reset_err", {31'd0, ERR}, 32'd0);
        chk("reset_data_out", DATA_OUT, 32'd0);
        MOV = 1'b0;
        RST_N = 1'b1;
        @(negedge CLK);

        // Word write/read and endianness
        do_op("wr_word_10", 1'b0, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        do_op("rd_word_10", 1'b1, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        do_op("rd_byte_11", 1'b1, 2'b00, 32'h11, 32'h0, 32'h000000AD, 1'b0, 0);
        do_op("rd_half_12", 1'b1, 2'b01, 32'h12, 32'h0, 32'h0000BEEF, 1'b0, 0);
        do_op("wr_byte_13", 1'b0, 2'b00, 32'h13, 32'hFFFFFF55, 32'h0000BEEF, 1'b0, 0);
        do_op("rd_word_10b", 1'b1, 2'b10, 32'h10, 32'h0, 32'hDEADBE55, 1'b0, 0);

        // Misalignment and reserved type
        do_op("wr_word_20", 1'b0, 2'b10, 32'h20, 32'h01020304, 32'hDEADBE55, 1'b0, 0);
        do_op("wr_word_21_mis", 1'b0, 2'b10, 32'h21, 32'h12345678, 32'hDEADBE55, 1'b1, 0);
        do_op("rd_word_20", 1'b1, 2'b10, 32'h20, 32'h0, 32'h01020304, 1'b0, 0);
        do_op("rd_half_03_mis", 1'b1, 2'b01, 32'h03, 32'h0, 32'h01020304, 1'b1, 0);
        do_op("rd_type11", 1'b1, 2'b11, 32'h00, 32'h0, 32'h01020304, 1'b1, 0);
        do_op("rd_word_22_mis", 1'b1, 2'b10, 32'h22, 32'h0, 32'h01020304, 1'b1, 0);

        // Address wrap and top of memory
        do_op("wr_word_104", 1'b0, 2'b10, 32'h00000104, 32'hCAFEF00D, 32'h01020304, 1'b0, 0);
        do_op("rd_word_04", 1'b1, 2'b10, 32'h04, 32'h0, 32'hCAFEF00D, 1'b0, 0);
        do_op("rd_half_106", 1'b1, 2'b01, 32'h106, 32'h0, 32'h0000F00D, 1'b0, 0);
        do_op("wr_word_fc", 1'b0, 2'b10, 32'hFC, 32'h0BADC0DE, 32'h0000F00D, 1'b0, 0);
        do_op("rd_byte_ff", 1'b1, 2'b00, 32'hFF, 32'h0, 32'h000000DE, 1'b0, 0);

        // Handshake hold: MOC stays high, no re-trigger
        do_op("rd_word_10_hold", 1'b1, 2'b10, 32'h10, 32'h0, 32'hDEADBE55, 1'b0, 6);
        do_op("wr_byte_40_hold", 1'b0, 2'b00, 32'h40, 32'h00000077, 32'hDEADBE55, 1'b0, 6);
        do_op("rd_byte_40", 1'b1, 2'b00, 32'h40, 32'h0, 32'h00000077, 1'b0, 0);

        // Reset mid-operation aborts the write
        do_op("wr_word_30", 1'b0, 2'b10, 32'h30, 32'hA5A5A5A5, 32'h00000077, 1'b0, 0);
        @(negedge CLK);
        MOV = 1'b1; RW = 1'b0; DATA_TYPE = 2'b10; ADDR = 32'h30; DATA_IN = 32'h11111111;
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        chk("abort_moc", {31'd0, MOC}, 32'd0);
        chk("abort_err", {31'd0, ERR}, 32'd0);
        chk("abort_data_out", DATA_OUT, 32'd0);
        RST_N = 1'b1; MOV = 1'b0;
        repeat (LATENCY + 1) begin
            @(negedge CLK);
            chk("abort_idle_moc", {31'd0, MOC}, 32'd0);
        end
        do_op("rd_word_30", 1'b1, 2'b10, 32'h30, 32'h0, 32'hA5A5A5A5, 1'b0, 0);

        repeat (4) @(negedge CLK);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
